alu_loader_seq: RTL and testbench
=================================

Name: alu_loader_seq

Overview:
- Parametrised successor to the 8-bit button-loaded ALU top.
- Three push-buttons load operand A, operand B and a 6-bit opcode from a shared data bus.
- Adds rising-edge detection, load-state tracking, a registered result, valid and error indication, and optional status flags.
- Sits between the board switches/buttons and the LED bank.

Parameters:
- N_BITS, 8, operand and result width (min 4).
- N_OP, 6, opcode width; opcode is taken from i_data_bus[N_OP-1:0]. Requires N_BITS >= N_OP.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_data_bus  in  N_BITS  shared operand/opcode bus.
- i_bt_1  in  1  load A, level input.
- i_bt_2  in  1  load B, level input.
- i_bt_3  in  1  load opcode, level input.
- o_leds  out  N_BITS  registered ALU result.
- o_valid  out  1  high when o_leds reflects the currently loaded A, B and opcode.
- o_op_err  out  1  loaded opcode is unsupported.

Behaviour:
- Reset (async assert, sync release): A, B, opcode = 0; button history regs = 0; load flags = 0; o_leds = 0; o_valid = 0; o_op_err = 0. Reset mid-sequence discards all loaded values.
- Edge detect: per button, a registered previous value. load_x = i_bt_x & ~prev_x.
  - A button held high for many cycles produces exactly one load, on the first rising clock edge at which it is sampled high.
  - Bus changes while the button is held are ignored.
- Load: on a load pulse, the target register captures i_data_bus at that clock edge and its loaded flag sets.
- Simultaneous pulses in one cycle: priority bt_1 > bt_2 > bt_3. Only the highest-priority load occurs; the lower ones are dropped, and the user must re-press.
- Load FSM:
  - States: EMPTY, PARTIAL, READY.
  - EMPTY -> PARTIAL on the first load.
  - PARTIAL -> READY when all three flags are set.
  - READY stays READY; any new load re-triggers computation.
- Result register, updated one cycle after any load while in READY (or on entering READY):
  - o_leds <= f(A, B, op); o_valid <= 1.
  - Latency: load edge k -> o_leds and o_valid at edge k+1.
  - During cycle k..k+1 o_valid is 0. o_valid is low whenever the FSM is not READY.
- Opcodes (N_OP=6):
  - 100000 ADD A+B
  - 100010 SUB A-B
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 100111 NOR
  - 000011 SRA: A >>> B; B >= N_BITS gives all sign bits.
  - 000010 SRL: A >> B; B >= N_BITS gives 0.
- All arithmetic is mod 2^N_BITS.
- Unsupported opcode: o_leds <= 0, o_op_err <= 1, o_valid <= 1. o_op_err clears on the next computation with a valid opcode.

Optional Feature:
- Macro: ALU_LOADER_FLAGS_EN.
- When defined, three extra ports are added:
  - o_zero (result == 0).
  - o_carry: carry-out for ADD; borrow (A < B unsigned) for SUB; 0 otherwise.
  - o_overflow: signed two's-complement overflow for ADD/SUB; 0 otherwise.
- All three are registered with o_leds, reset to 0, and forced to 0 on an unsupported opcode.
- When not defined: ports absent, no flag logic; all other behaviour identical.

Test Plan:
- Reset, then A=1, B=1, op=100000 with one-cycle-separated presses: o_leds=8'h02 one cycle after the op load; o_valid=1; o_valid=0 before the third load.
- A=35, B=20, op=100010: o_leds=8'd15. Then re-press bt_1 with bus=100: next cycle o_valid=0, following cycle o_leds=8'd80, o_valid=1.
- Hold bt_1 high 10 cycles while the bus changes 5 -> 9: A=5 (single load). Assert bt_1 and bt_2 in the same cycle with bus=7: only A=7, B unchanged.
- A=8'h80, B=2, op=000011: o_leds=8'hE0. Same with op=000010: 8'h20. B=9 with SRA: 8'hFF.
- op=111111: o_leds=0, o_op_err=1, o_valid=1. Then load op=100100 with A=8'hF0, B=8'h3C: o_leds=8'h30, o_op_err=0.
- With ALU_LOADER_FLAGS_EN: A=127, B=1 ADD gives 8'h80, o_overflow=1, o_carry=0. A=1, B=2 SUB gives 8'hFF, o_carry=1. Deassert i_reset_n mid-sequence (after A only): all outputs 0 immediately; FSM returns to EMPTY.

Source files
------------

// File: rtl/alu_loader_seq.sv
// Button-loaded ALU: edge-detected loads of A, B and opcode from a shared bus, registered result.
// Optional status flags (zero/carry/overflow) are enabled by defining ALU_LOADER_FLAGS_EN.
module alu_loader_seq #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [N_BITS-1:0] i_data_bus,
    input  logic              i_bt_1,
    input  logic              i_bt_2,
    input  logic              i_bt_3,
    output logic [N_BITS-1:0] o_leds,
    output logic              o_valid,
    output logic              o_op_err
`ifdef ALU_LOADER_FLAGS_EN
    ,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_overflow
`endif
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        READY   = 2'd2
    } state_t;

    localparam logic [N_OP-1:0]   OP_ADD = N_OP'(6'b100000);
    localparam logic [N_OP-1:0]   OP_SUB = N_OP'(6'b100010);
    localparam logic [N_OP-1:0]   OP_AND = N_OP'(6'b100100);
    localparam logic [N_OP-1:0]   OP_OR  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0]   OP_XOR = N_OP'(6'b100110);
    localparam logic [N_OP-1:0]   OP_NOR = N_OP'(6'b100111);
    localparam logic [N_OP-1:0]   OP_SRA = N_OP'(6'b000011);
    localparam logic [N_OP-1:0]   OP_SRL = N_OP'(6'b000010);
    localparam logic [N_BITS-1:0] SHIFT_LIM = N_BITS'(N_BITS);

    logic [N_BITS-1:0] a_r;
    logic [N_BITS-1:0] b_r;
    logic [N_OP-1:0]   op_r;
    logic [2:0]        prev_r;
    logic [2:0]        flag_r;
    logic              pend_r;
    state_t            state_r;

    logic [2:0]        edge_s;
    logic [2:0]        sel_s;
    logic [2:0]        flag_nxt_s;
    logic [N_BITS-1:0] res_s;
    logic              err_s;

    // Rising-edge detect per button, then keep only the highest-priority load (bt_1 > bt_2 > bt_3)
    always_comb begin
        edge_s = {i_bt_3, i_bt_2, i_bt_1} & ~prev_r;
        sel_s  = 3'b000;
        if (edge_s[0]) begin
            sel_s = 3'b001;
        end else if (edge_s[1]) begin
            sel_s = 3'b010;
        end else if (edge_s[2]) begin
            sel_s = 3'b100;
        end else begin
            sel_s = 3'b000;
        end
        flag_nxt_s = flag_r | sel_s;
    end

    // ALU datapath on the loaded operands; unsupported opcodes yield zero with an error
    always_comb begin
        res_s = '0;
        err_s = 1'b0;
        case (op_r)
            OP_ADD: res_s = a_r + b_r;
            OP_SUB: res_s = a_r - b_r;
            OP_AND: res_s = a_r & b_r;
            OP_OR:  res_s = a_r | b_r;
            OP_XOR: res_s = a_r ^ b_r;
            OP_NOR: res_s = ~(a_r | b_r);
            OP_SRA: begin
                if (b_r >= SHIFT_LIM) begin
                    res_s = {N_BITS{a_r[N_BITS-1]}};
                end else begin
                    res_s = N_BITS'($signed(a_r) >>> b_r);
                end
            end
            OP_SRL: begin
                if (b_r >= SHIFT_LIM) begin
                    res_s = '0;
                end else begin
                    res_s = a_r >> b_r;
                end
            end
            default: begin
                res_s = '0;
                err_s = 1'b1;
            end
        endcase
    end

`ifdef ALU_LOADER_FLAGS_EN
    logic [N_BITS:0] sum_s;
    logic [N_BITS-1:0] diff_s;
    logic            carry_s;
    logic            ovf_s;

    // Carry/borrow and signed overflow, meaningful only for ADD and SUB
    always_comb begin
        sum_s   = {1'b0, a_r} + {1'b0, b_r};
        diff_s  = a_r - b_r;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op_r)
            OP_ADD: begin
                carry_s = sum_s[N_BITS];
                ovf_s   = (a_r[N_BITS-1] == b_r[N_BITS-1]) && (sum_s[N_BITS-1] != a_r[N_BITS-1]);
            end
            OP_SUB: begin
                carry_s = (a_r < b_r);
                ovf_s   = (a_r[N_BITS-1] != b_r[N_BITS-1]) && (diff_s[N_BITS-1] != a_r[N_BITS-1]);
            end
            default: begin
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
    end
`endif

    // Operand capture, load FSM and registered result; a load drops o_valid until the recompute edge
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            prev_r   <= 3'b000;
            flag_r   <= 3'b000;
            pend_r   <= 1'b0;
            state_r  <= EMPTY;
            o_leds   <= '0;
            o_valid  <= 1'b0;
            o_op_err <= 1'b0;
`ifdef ALU_LOADER_FLAGS_EN
            o_zero     <= 1'b0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
`endif
        end else begin
            prev_r <= {i_bt_3, i_bt_2, i_bt_1};
            case (sel_s)
                3'b001:  a_r  <= i_data_bus;
                3'b010:  b_r  <= i_data_bus;
                3'b100:  op_r <= i_data_bus[N_OP-1:0];
                default: ;
            endcase
            case (state_r)
                EMPTY:   if (sel_s != 3'b000) state_r <= PARTIAL;
                PARTIAL: if (&flag_nxt_s) state_r <= READY;
                READY:   state_r <= READY;
                default: state_r <= EMPTY;
            endcase
            if (sel_s != 3'b000) begin
                flag_r  <= flag_nxt_s;
                pend_r  <= 1'b1;
                o_valid <= 1'b0;
            end else if (pend_r && (state_r == READY)) begin
                pend_r   <= 1'b0;
                o_leds   <= res_s;
                o_op_err <= err_s;
                o_valid  <= 1'b1;
`ifdef ALU_LOADER_FLAGS_EN
                o_zero     <= (res_s == '0) && !err_s;
                o_carry    <= carry_s && !err_s;
                o_overflow <= ovf_s && !err_s;
`endif
            end else begin
                pend_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_loader_seq.sv
// Scoreboard bench for alu_loader_seq: directed presses push expected results, a monitor checks on o_valid rise.
module tb_alu_loader_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus;
    logic       bt1, bt2, bt3;
    logic [7:0] o_leds;
    logic       o_valid;
    logic       o_op_err;
`ifdef ALU_LOADER_FLAGS_EN
    logic       o_zero, o_carry, o_overflow;
`endif

    alu_loader_seq #(.N_BITS(8), .N_OP(6)) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_data_bus (bus),
        .i_bt_1     (bt1),
        .i_bt_2     (bt2),
        .i_bt_3     (bt3),
        .o_leds     (o_leds),
        .o_valid    (o_valid),
        .o_op_err   (o_op_err)
`ifdef ALU_LOADER_FLAGS_EN
        ,
        .o_zero     (o_zero),
        .o_carry    (o_carry),
        .o_overflow (o_overflow)
`endif
    );

    typedef struct packed {
        logic [7:0] leds;
        logic       err;
        logic       chk_fl;
        logic       z;
        logic       c;
        logic       v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic er);
        q.push_back({l, er, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic push_fl(input logic [7:0] l, input logic z, input logic c, input logic v);
        q.push_back({l, 1'b0, 1'b1, z, c, v});
    endtask

    // idx: 1=A, 2=B, 3=op, 12=A and B together
    task automatic press(input int idx, input logic [7:0] d);
        @(negedge clk);
        bus = d;
        bt1 = (idx == 1) || (idx == 12);
        bt2 = (idx == 2) || (idx == 12);
        bt3 = (idx == 3);
        @(negedge clk);
        bt1 = 1'b0;
        bt2 = 1'b0;
        bt3 = 1'b0;
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_leds"}, o_leds, 0);
        check({name, "_valid"}, o_valid, 0);
        check({name, "_err"}, o_op_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: each o_valid rise must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && o_valid && !prev_v) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got leds %0h with no expected result", o_leds);
            end else begin
                e = q.pop_front();
                check("leds", o_leds, e.leds);
                check("op_err", o_op_err, e.err);
`ifdef ALU_LOADER_FLAGS_EN
                if (e.chk_fl) begin
                    check("zero", o_zero, e.z);
                    check("carry", o_carry, e.c);
                    check("overflow", o_overflow, e.v);
                end
`endif
            end
        end
        prev_v = o_valid;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus = 8'h00;
        bt1 = 1'b0;
        bt2 = 1'b0;
        bt3 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_leds", o_leds, 0);
        check("rst_valid", o_valid, 0);
        check("rst_err", o_op_err, 0);
        rst_n = 1'b1;

        // 1 + 1 with ADD; nothing valid before the opcode load
        press(1, 8'd1);
        press(2, 8'd1);
        check("valid_before_op", o_valid, 0);
        push(8'h02, 1'b0);
        press(3, 8'h20);
        check("valid_low_after_op", o_valid, 0);

        // Each load in READY recomputes
        push(8'd36, 1'b0);  press(1, 8'd35);
        push(8'd55, 1'b0);  press(2, 8'd20);
        push(8'd15, 1'b0);  press(3, 8'h22);
        push(8'd80, 1'b0);  press(1, 8'd100);
        check("valid_low_reload", o_valid, 0);

        // Held button: one load only, bus change ignored
        push(8'hF1, 1'b0);
        @(negedge clk);
        bus = 8'd5;
        bt1 = 1'b1;
        repeat (5) @(negedge clk);
        bus = 8'd9;
        repeat (5) @(negedge clk);
        bt1 = 1'b0;

        // bt_1 and bt_2 together: only A loads
        push(8'hF3, 1'b0);  press(12, 8'd7);

        // Shifts
        push(8'h6C, 1'b0);  press(1, 8'h80);
        push(8'h7E, 1'b0);  press(2, 8'd2);
        push(8'hE0, 1'b0);  press(3, 8'h03);
        push(8'h20, 1'b0);  press(3, 8'h02);
        push(8'h00, 1'b0);  press(2, 8'd9);
        push(8'hFF, 1'b0);  press(3, 8'h03);

        // Unsupported opcode, then logic ops
        push(8'h00, 1'b1);  press(3, 8'h3F);
        push(8'h00, 1'b1);  press(1, 8'hF0);
        push(8'h00, 1'b1);  press(2, 8'h3C);
        push(8'h30, 1'b0);  press(3, 8'h24);
        push(8'hFC, 1'b0);  press(3, 8'h25);
        push(8'hCC, 1'b0);  press(3, 8'h26);
        push(8'h03, 1'b0);  press(3, 8'h27);
        repeat (2) @(negedge clk);

        // Reset mid-sequence discards loaded values
        async_reset("mid_rst1");
        press(1, 8'd10);
        async_reset("mid_rst2");
        press(2, 8'd3);
        press(3, 8'h20);
        repeat (3) @(negedge clk);
        check("valid_after_rst_partial", o_valid, 0);
        push(8'd7, 1'b0);   press(1, 8'd4);

`ifdef ALU_LOADER_FLAGS_EN
        push_fl(8'h82, 1'b0, 1'b0, 1'b1);  press(1, 8'd127);
        push_fl(8'h80, 1'b0, 1'b0, 1'b1);  press(2, 8'd1);
        push_fl(8'h02, 1'b0, 1'b0, 1'b0);  press(1, 8'd1);
        push_fl(8'h03, 1'b0, 1'b0, 1'b0);  press(2, 8'd2);
        push_fl(8'hFF, 1'b0, 1'b1, 1'b0);  press(3, 8'h22);
        push_fl(8'h00, 1'b1, 1'b0, 1'b0);  press(1, 8'd2);
`endif

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
